// File: rtl/ddr3_app_pkg.sv
// Shared constants and types for the MIG-style user-interface responder.
package ddr3_app_pkg;

   localparam int unsigned APP_ADDR_W = 28;
   localparam int unsigned APP_DATA_W = 512;
   localparam int unsigned APP_MASK_W = APP_DATA_W / 8;
   localparam int unsigned APP_CMD_W  = 3;
   // Word index keeps every address bit above the 64-bit column bits.
   localparam int unsigned WORD_IDX_W = APP_ADDR_W - 3;

   localparam logic [APP_CMD_W-1:0] APP_CMD_WRITE = 3'b000;
   localparam logic [APP_CMD_W-1:0] APP_CMD_READ  = 3'b001;

   typedef struct packed {
      logic [APP_CMD_W-1:0]  cmd;
      logic [WORD_IDX_W-1:0] word;
   } cmdq_entry_t;

endpackage

// File: rtl/ddr3_resp_fifo.sv
// Synchronous FIFO with registered count; full/empty derive from the count only.
module ddr3_resp_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] store_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = store_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) store_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/ddr3_app_responder.sv
// Memory-side responder for the MIG 4:1 user interface backed by a 512-bit array.
// Optional LFSR command backpressure is enabled by defining DDR3_RESP_BACKPRESSURE_EN.
module ddr3_app_responder
   import ddr3_app_pkg::*;
#(
   parameter int unsigned MEM_AW       = 10,
   parameter int unsigned RD_LATENCY   = 8,
   parameter int unsigned CMDQ_DEPTH   = 4,
   parameter int unsigned WDFQ_DEPTH   = 4,
   parameter int unsigned CALIB_CYCLES = 64
) (
   input  logic                  ui_clk,
   input  logic                  sys_rst,
   input  logic [APP_ADDR_W-1:0] app_addr,
   input  logic [APP_CMD_W-1:0]  app_cmd,
   input  logic                  app_en,
   input  logic [APP_DATA_W-1:0] app_wdf_data,
   input  logic                  app_wdf_end,
   input  logic [APP_MASK_W-1:0] app_wdf_mask,
   input  logic                  app_wdf_wren,
   output logic [APP_DATA_W-1:0] app_rd_data,
   output logic                  app_rd_data_end,
   output logic                  app_rd_data_valid,
   output logic                  app_rdy,
   output logic                  app_wdf_rdy,
   output logic                  init_calib_complete,
   output logic                  cmd_err
);

   localparam int unsigned MemWords = 2 ** MEM_AW;
   localparam int unsigned CalW     = $clog2(CALIB_CYCLES + 1);
   localparam int unsigned WdfW     = APP_DATA_W + APP_MASK_W;
   localparam int unsigned CmdCntW  = $clog2(CMDQ_DEPTH + 1);
   localparam int unsigned WdfCntW  = $clog2(WDFQ_DEPTH + 1);

   logic [CalW-1:0]       cal_cnt_q, cal_cnt_d;
   logic                  cal_done_q, cal_done_d;
   logic                  cmd_err_q, cmd_err_d;
   cmdq_entry_t           cmd_in, cmd_head;
   logic                  cmdq_full, cmdq_empty, wdfq_full, wdfq_empty;
   logic [CmdCntW-1:0]    cmdq_count;
   logic [WdfCntW-1:0]    wdfq_count;
   logic [WdfW-1:0]       wdf_head;
   logic                  cmd_push, wdf_push, cmd_pop, wdf_pop, mem_we, rd_fire, bp_block;
   logic [MEM_AW-1:0]     head_idx;
   logic [APP_DATA_W-1:0] mem [MemWords];
   logic [RD_LATENCY-1:0] rd_vld_q;
   logic [APP_DATA_W-1:0] rd_dat_q [RD_LATENCY];
   logic                  unused_ok;

   assign unused_ok = ^{cmdq_count, wdfq_count, app_wdf_end, app_addr[2:0],
                        cmd_head.word[WORD_IDX_W-1:MEM_AW]};

`ifdef DDR3_RESP_BACKPRESSURE_EN
   logic [7:0] lfsr_q, lfsr_d;

   // Fibonacci taps 8,6,5,4; free-runs once calibration completes.
   always_comb begin
      lfsr_d = lfsr_q;
      if (cal_done_q) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge ui_clk or posedge sys_rst) begin
      if (sys_rst) lfsr_q <= 8'hA5;
      else         lfsr_q <= lfsr_d;
   end

   assign bp_block = (lfsr_q[1:0] == 2'b00);
`else
   assign bp_block = 1'b0;
`endif

   assign app_rdy             = cal_done_q & ~cmdq_full & ~bp_block;
   assign app_wdf_rdy         = cal_done_q & ~wdfq_full;
   assign init_calib_complete = cal_done_q;
   assign cmd_err             = cmd_err_q;
   assign cmd_push            = app_en & app_rdy;
   assign wdf_push            = app_wdf_wren & app_wdf_rdy;
   assign cmd_in.cmd          = app_cmd;
   assign cmd_in.word         = app_addr[APP_ADDR_W-1:3];
   assign head_idx            = cmd_head.word[MEM_AW-1:0];

   ddr3_resp_fifo #(.Width($bits(cmdq_entry_t)), .Depth(CMDQ_DEPTH)) u_cmdq (
      .clk_i   (ui_clk),
      .rst_i   (sys_rst),
      .push_i  (cmd_push),
      .wdata_i (cmd_in),
      .pop_i   (cmd_pop),
      .rdata_o (cmd_head),
      .full_o  (cmdq_full),
      .empty_o (cmdq_empty),
      .count_o (cmdq_count)
   );

   ddr3_resp_fifo #(.Width(WdfW), .Depth(WDFQ_DEPTH)) u_wdfq (
      .clk_i   (ui_clk),
      .rst_i   (sys_rst),
      .push_i  (wdf_push),
      .wdata_i ({app_wdf_mask, app_wdf_data}),
      .pop_i   (wdf_pop),
      .rdata_o (wdf_head),
      .full_o  (wdfq_full),
      .empty_o (wdfq_empty),
      .count_o (wdfq_count)
   );

   always_comb begin
      cal_cnt_d  = cal_cnt_q;
      cal_done_d = cal_done_q;
      if (!cal_done_q) begin
         cal_cnt_d = cal_cnt_q + 1'b1;
         if (cal_cnt_q == CalW'(CALIB_CYCLES - 1)) cal_done_d = 1'b1;
      end
   end

   // In-order execution: a write at the head waits for its data beat.
   always_comb begin
      cmd_pop   = 1'b0;
      wdf_pop   = 1'b0;
      mem_we    = 1'b0;
      rd_fire   = 1'b0;
      cmd_err_d = cmd_err_q;
      if (!cmdq_empty) begin
         case (cmd_head.cmd)
            APP_CMD_WRITE: begin
               if (!wdfq_empty) begin
                  cmd_pop = 1'b1;
                  wdf_pop = 1'b1;
                  mem_we  = 1'b1;
               end
            end
            APP_CMD_READ: begin
               cmd_pop = 1'b1;
               rd_fire = 1'b1;
            end
            default: begin
               cmd_pop   = 1'b1;
               cmd_err_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge ui_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cal_cnt_q  <= '0;
         cal_done_q <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         cal_cnt_q  <= cal_cnt_d;
         cal_done_q <= cal_done_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   // Array is deliberately outside the reset domain so contents survive sys_rst.
   always_ff @(posedge ui_clk) begin
      if (mem_we) begin
         for (int b = 0; b < int'(APP_MASK_W); b++) begin
            if (!wdf_head[APP_DATA_W + b]) mem[head_idx][b*8 +: 8] <= wdf_head[b*8 +: 8];
         end
      end
   end

   // Data stages only load behind a valid, so the last stage holds between beats.
   always_ff @(posedge ui_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rd_vld_q <= '0;
         for (int i = 0; i < int'(RD_LATENCY); i++) rd_dat_q[i] <= '0;
      end else begin
         rd_vld_q[0] <= rd_fire;
         if (rd_fire) rd_dat_q[0] <= mem[head_idx];
         for (int i = 1; i < int'(RD_LATENCY); i++) begin
            rd_vld_q[i] <= rd_vld_q[i-1];
            if (rd_vld_q[i-1]) rd_dat_q[i] <= rd_dat_q[i-1];
         end
      end
   end

   assign app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
   assign app_rd_data_end   = rd_vld_q[RD_LATENCY-1];
   assign app_rd_data       = rd_dat_q[RD_LATENCY-1];

endmodule
